wb_line_buffer: RTL and testbench

//  Write-back buffer between the cache and the memory.
//  The cache pushes dirty 32-bit lines on eviction and continues at once.
//  The buffer drains lines to memory one at a time with a wrt/cmplt handshake.

---
 rtl/wb_line_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_wb_line_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_line_buffer.sv
// ---------------------------------------------------------------------------
// wb_line_buffer
//
// Write-back buffer that sits between the cache and memory. The cache pushes
// dirty lines when it evicts them and carries on immediately. The buffer
// writes those lines to memory one at a time using a wrt/cmplt handshake.
// Line fetches look in the buffer first, so a fetch of an evicted line never
// returns stale memory contents.
//
// Ports
//   clk         cache clock; all state changes on the rising edge
//   reset       synchronous, active-low reset
//   wb_valid    cache presents an evicted line
//   wb_addr     byte address of the evicted line
//   wb_data     evicted line data
//   wb_ready    buffer can accept a line (push = wb_valid & wb_ready)
//   fetch_addr  address of the line the cache is about to fetch
//   fetch_hit   combinational: a valid entry holds the fetched line
//   fetch_data  combinational: data of the youngest matching entry, else 0
//   mem_wrt     write request to memory
//   mem_addr    line-aligned address of the entry being written
//   mem_data    data of the entry being written
//   mem_cmplt   memory done (a level that may stay high for several cycles)
//   count       number of occupied entries
//   empty       count == 0
//   full        count == DEPTH
// ---------------------------------------------------------------------------
module wb_line_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 24,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DW-1:0]            wb_data,
  output logic                     wb_ready,
  input  logic [AW-1:0]            fetch_addr,
  output logic                     fetch_hit,
  output logic [DW-1:0]            fetch_data,
  output logic                     mem_wrt,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  input  logic                     mem_cmplt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = AW - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Entry storage and queue bookkeeping
  logic [LW-1:0]    line_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Drain FSM and memory-side registers
  state_t           state_q, state_d;
  logic             mem_wrt_q, mem_wrt_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_data_q, mem_data_d;
  logic             pop_en;

  // Push path
  logic [LW-1:0]    wb_line;
  logic [LW-1:0]    fetch_line;
  logic [DEPTH-1:0] coal_match;
  logic [DEPTH-1:0] fetch_match;
  logic [PW-1:0]    coal_idx;
  logic             head_busy;
  logic             push_acc;
  logic             coal_en;
  logic             alloc_en;

  // Byte offset within a line plays no part in line matching.
  logic unused_low_bits;
  assign unused_low_bits = ^{wb_addr[1:0], fetch_addr[1:0]};

  assign wb_line    = wb_addr[AW-1:2];
  assign fetch_line = fetch_addr[AW-1:2];

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign wb_ready = ~full;
  assign count    = count_q;
  assign mem_wrt  = mem_wrt_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

  // The head must not be modified once it is being copied into the memory
  // registers (IDLE with data) or is out on the bus (ISSUE); a coalescing
  // write there would be lost after the pop.
  assign head_busy = (state_q == ISSUE) || ((state_q == IDLE) && !empty);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign coal_match[gi]  = valid_q[gi] && (line_q[gi] == wb_line) &&
                               !(head_busy && (head_q == PW'(gi)));
      assign fetch_match[gi] = valid_q[gi] && (line_q[gi] == fetch_line);
    end
  endgenerate

  // Coalescing keeps at most one non-busy copy of any line, so at most one
  // bit of coal_match can be set.
  always_comb begin
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (coal_match[i]) coal_idx = PW'(i);
    end
  end

  assign push_acc = wb_valid && !full;
  assign coal_en  = push_acc && (|coal_match);
  assign alloc_en = push_acc && !(|coal_match);

  always_comb begin
    count_d = count_q + CW'(alloc_en) - CW'(pop_en);
  end

  // Lookup walks oldest to youngest so the youngest match is left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fetch_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (fetch_match[idx]) fetch_data = data_q[idx];
    end
  end
  assign fetch_hit = |fetch_match;

  // Drain FSM: next state and memory-side register values
  always_comb begin
    state_d    = state_q;
    mem_wrt_d  = mem_wrt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    pop_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          mem_wrt_d  = 1'b1;
          mem_addr_d = {line_q[head_q], 2'b00};
          mem_data_d = data_q[head_q];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_wrt_d = 1'b1;
        if (mem_cmplt) begin
          mem_wrt_d = 1'b0;
          pop_en    = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        // Wait for cmplt to drop so one cmplt pulse retires one line only.
        mem_wrt_d = 1'b0;
        if (!mem_cmplt) state_d = IDLE;
      end
      default: begin
        mem_wrt_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_wrt_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_wrt_q  <= mem_wrt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      // Pop and allocate never target the same slot: that would need a
      // push while full, which wb_ready blocks.
      if (pop_en) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (alloc_en) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      line_q[tail_q] <= wb_line;
      data_q[tail_q] <= wb_data;
    end
    if (coal_en) begin
      data_q[coal_idx] <= wb_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(alloc_en && full));
      assert (!(pop_en && empty));
      assert (!(coal_en && pop_en && (coal_idx == head_q)));
    end
  end
`endif

endmodule

// File: tb/tb_wb_line_buffer.sv
module tb_wb_line_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 24;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic [AW-1:0] fetch_addr;
  logic          fetch_hit;
  logic [DW-1:0] fetch_data;
  logic          mem_wrt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_cmplt;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  wb_line_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .fetch_addr (fetch_addr),
    .fetch_hit  (fetch_hit),
    .fetch_data (fetch_data),
    .mem_wrt    (mem_wrt),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_cmplt  (mem_cmplt),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an ordered list of queued lines plus the line currently
  // handed to memory.
  typedef struct {
    logic [AW-3:0] line;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  bit            m_sending;   // head has been handed to memory, awaiting cmplt
  bit            m_wait_low;  // a line was retired; cmplt must drop first
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the inputs present just before the coming clock edge.
  task automatic model_step();
    int   n;
    bit   busy;
    bit   retire;
    bit   merged;
    ent_t e;
    if (!reset) begin
      q.delete();
      m_sending  = 0;
      m_wait_low = 0;
      m_addr     = '0;
      m_data     = '0;
      return;
    end
    n      = q.size();
    busy   = m_sending || (!m_wait_low && n > 0);
    retire = m_sending && mem_cmplt;
    if (wb_valid && n < DEPTH) begin
      merged = 0;
      for (int i = (busy ? 1 : 0); i < n; i++) begin
        if (!merged && q[i].line == wb_addr[AW-1:2]) begin
          q[i].data = wb_data;
          merged = 1;
        end
      end
      if (!merged) begin
        e.line = wb_addr[AW-1:2];
        e.data = wb_data;
        q.push_back(e);
      end
    end
    if (retire) begin
      void'(q.pop_front());
      m_sending  = 0;
      m_wait_low = 1;
    end else if (m_wait_low) begin
      if (!mem_cmplt) m_wait_low = 0;
    end else if (!m_sending && n > 0) begin
      m_sending = 1;
      m_addr    = {q[0].line, 2'b00};
      m_data    = q[0].data;
    end
  endtask

  task automatic check_all();
    bit            eh;
    logic [DW-1:0] ed;
    eh = 0;
    ed = '0;
    foreach (q[i]) begin
      if (q[i].line == fetch_addr[AW-1:2]) begin
        eh = 1;
        ed = q[i].data;
      end
    end
    chk("count",    count,    q.size());
    chk("empty",    empty,    q.size() == 0);
    chk("full",     full,     q.size() == DEPTH);
    chk("wb_ready", wb_ready, q.size() != DEPTH);
    chk("mem_wrt",  mem_wrt,  m_sending);
    if (m_sending) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
    end
    chk("fetch_hit",  fetch_hit,  eh);
    chk("fetch_data", fetch_data, ed);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Memory side: wait (bounded) for a request, check it, then complete it.
  task automatic serve(input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    int k;
    k = 0;
    while (mem_wrt !== 1'b1 && k < 40) begin
      cycle();
      k++;
    end
    chk("serve_req",  mem_wrt,  1'b1);
    chk("serve_addr", mem_addr, ea);
    chk("serve_data", mem_data, ed);
    $display("serve: addr=%06h data=%08h after %0d wait cycles", mem_addr, mem_data, k);
    mem_cmplt = 1'b1;
    cycle();
    mem_cmplt = 1'b0;
    cycle();
  endtask

  logic [AW-1:0] fill_addr [4];

  initial begin
    fill_addr[0] = 24'h000004;
    fill_addr[1] = 24'h000008;
    fill_addr[2] = 24'h00000C;
    fill_addr[3] = 24'h000010;
    reset      = 1'b0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    fetch_addr = '0;
    mem_cmplt  = 1'b0;

    // Reset held low for two cycles
    cycle();
    cycle();
    chk("rst_count",   count,    0);
    chk("rst_empty",   empty,    1'b1);
    chk("rst_ready",   wb_ready, 1'b1);
    chk("rst_wrt",     mem_wrt,  1'b0);
    chk("rst_maddr",   mem_addr, 0);
    chk("rst_mdata",   mem_data, 0);
    $display("reset: count=%0d empty=%0b wb_ready=%0b mem_wrt=%0b", count, empty, wb_ready, mem_wrt);
    reset = 1'b1;

    // Single line drained with a 4-cycle memory latency
    wb_valid = 1'b1;
    wb_addr  = 24'h010000;
    wb_data  = 32'hDEADBEEF;
    cycle();
    wb_valid = 1'b0;
    chk("single_wrt_c1", mem_wrt, 1'b0);
    cycle();
    chk("single_wrt_c2", mem_wrt,  1'b1);
    chk("single_addr",   mem_addr, 24'h010000);
    chk("single_data",   mem_data, 32'hDEADBEEF);
    $display("single: mem_wrt=%0b addr=%06h data=%08h", mem_wrt, mem_addr, mem_data);
    repeat (3) cycle();
    mem_cmplt = 1'b1;
    cycle();
    chk("single_empty",   empty,   1'b1);
    chk("single_wrt_pop", mem_wrt, 1'b0);
    cycle();
    chk("single_wrt_gap", mem_wrt, 1'b0);
    mem_cmplt = 1'b0;
    cycle();
    cycle();

    // Fill to capacity with memory stalled
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1;
      wb_addr  = fill_addr[i];
      wb_data  = 32'hA0000000 + 32'(i);
      cycle();
      $display("fill: push addr=%06h count=%0d", wb_addr, count);
    end
    chk("fill_full",  full,     1'b1);
    chk("fill_ready", wb_ready, 1'b0);
    wb_addr = 24'h000014;
    wb_data = 32'hBADBAD00;
    cycle();
    wb_valid = 1'b0;
    chk("fill_5th_count", count, 4);
    for (int i = 0; i < 4; i++) serve(fill_addr[i], 32'hA0000000 + 32'(i));
    chk("fill_drained", empty, 1'b1);

    // Coalescing behind a busy head
    wb_valid = 1'b1;
    wb_addr  = 24'h040000;
    wb_data  = 32'h33333333;
    cycle();
    wb_valid = 1'b0;
    cycle();
    chk("coal_head_busy", mem_wrt, 1'b1);
    wb_valid = 1'b1;
    wb_addr  = 24'h020004;
    wb_data  = 32'h11111111;
    cycle();
    wb_addr  = 24'h020006;
    wb_data  = 32'h22222222;
    cycle();
    wb_valid = 1'b0;
    chk("coal_count", count, 2);
    $display("coalesce: count=%0d", count);

    // Lookup while the coalesced line is queued
    fetch_addr = 24'h020007;
    #1;
    chk("lookup_hit",  fetch_hit,  1'b1);
    chk("lookup_data", fetch_data, 32'h22222222);
    fetch_addr = 24'h030000;
    #1;
    chk("lookup_miss_hit",  fetch_hit,  1'b0);
    chk("lookup_miss_data", fetch_data, 32'h0);
    $display("lookup: miss hit=%0b data=%08h", fetch_hit, fetch_data);
    serve(24'h040000, 32'h33333333);
    serve(24'h020004, 32'h22222222);

    // Reset in the middle of a transfer, then a stale cmplt
    wb_valid = 1'b1;
    wb_addr  = 24'h050000;
    wb_data  = 32'h55555555;
    cycle();
    wb_valid = 1'b0;
    cycle();
    chk("midrst_issue", mem_wrt, 1'b1);
    reset = 1'b0;
    cycle();
    chk("midrst_wrt",   mem_wrt, 1'b0);
    chk("midrst_count", count,   0);
    reset     = 1'b1;
    mem_cmplt = 1'b1;
    cycle();
    cycle();
    chk("stale_wrt",   mem_wrt, 1'b0);
    chk("stale_count", count,   0);
    $display("midrst: mem_wrt=%0b count=%0d", mem_wrt, count);
    mem_cmplt = 1'b0;
    cycle();

    // Randomised traffic over a small set of lines
    for (int c = 0; c < 400; c++) begin
      int l;
      l          = $urandom_range(0, 5);
      reset      = ($urandom_range(0, 99) != 0);
      wb_valid   = ($urandom_range(0, 1) == 1);
      wb_addr    = 24'h0A0000 + 24'(l * 4) + 24'($urandom_range(0, 3));
      wb_data    = $urandom;
      mem_cmplt  = ($urandom_range(0, 3) == 0);
      fetch_addr = 24'h0A0000 + 24'($urandom_range(0, 23));
      cycle();
    end
    $display("random: 400 cycles done, count=%0d", count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
